seq_addsub: RTL and testbench

Multi-cycle, parametrised adder/subtractor that replaces the fixed 16-bit single-cycle ripple adder where wide operands would make the combinational carry chain too long. It accepts a WIDTH-bit operation through a valid/ready handshake. It processes one SLICE-bit ripple segment per clock, registering the carry between segments, and returns sum, carry-out, signed overflow and zero through a second valid/ready handshake. It sits between the operand register stage and the ALU result mux.

---
 rtl/seq_addsub_pkg.sv | 13 +
 rtl/seq_addsub_rca_slice.sv | 40 ++++
 rtl/seq_addsub.sv | 135 +++++++++++++
 tb/tb_seq_addsub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared encodings for the sequential adder/subtractor: FSM states and op select.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_rca_slice.sv
// Full-adder cell and the SLICE-bit combinational ripple chain built from it.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    fa u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // c_msb is the carry into the top bit; XOR with co gives signed overflow.
  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit ripple segment per clock,
// carry registered between segments, valid/ready on both request and result sides.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output state_e           dbg_state
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE, out_valid only in DONE; no same-cycle turnaround.

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sub_q, sub_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  int                off;
  logic [SLICE-1:0]  slice_x, slice_y, slice_s;
  logic              slice_co, slice_cmsb;

  assign off     = int'(idx_q) * SLICE;
  assign slice_x = a_q[off +: SLICE];
  assign slice_y = b_q[off +: SLICE];

  rca_slice #(.SLICE(SLICE)) u_slice (
    .x     (slice_x),
    .y     (slice_y),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= OP_ADD;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + ~borrow, so the chain itself only ever adds.
          a_d     = a;
          sub_d   = sub;
          b_d     = (sub == OP_SUB) ? ~b : b;
          carry_d = (sub == OP_SUB) ? ~cin : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[off +: SLICE] = slice_s;
        carry_d             = slice_co;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  // Gated by out_valid so zero reads 0 outside DONE (including after reset).
  assign zero      = out_valid && (sum_q == '0);
  assign dbg_state = state_q;

  logic unused_sub;
  assign unused_sub = sub_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed cases on a 32/8 instance plus random sweeps on
// 16/16, 16/1 and 64/8 instances against an integer-arithmetic reference model.
module tb_seq_addsub;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  int wid [4] = '{32, 16, 16, 64};
  int nsl [4] = '{4, 1, 16, 8};

  logic [3:0]  in_valid_v, in_ready_v, cin_v, sub_v, out_valid_v, out_ready_v;
  logic [3:0]  cout_v, ovf_v, zero_v;
  logic [63:0] a_v [4];
  logic [63:0] b_v [4];

  logic [31:0] sum0;
  logic [15:0] sum1, sum2;
  logic [63:0] sum3;
  logic [1:0]  st0, st1, st2, st3;
  wire  [63:0] sum_w [4];
  wire  [1:0]  st_w [4];

  assign sum_w[0] = {32'd0, sum0};
  assign sum_w[1] = {48'd0, sum1};
  assign sum_w[2] = {48'd0, sum2};
  assign sum_w[3] = sum3;
  assign st_w[0] = st0;
  assign st_w[1] = st1;
  assign st_w[2] = st2;
  assign st_w[3] = st3;

  int checks = 0;
  int errors = 0;

  seq_addsub #(.WIDTH(32), .SLICE(8)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][31:0]), .b(b_v[0][31:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .sum(sum0),
    .cout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]), .dbg_state(st0));

  seq_addsub #(.WIDTH(16), .SLICE(16)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .sum(sum1),
    .cout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]), .dbg_state(st1));

  seq_addsub #(.WIDTH(16), .SLICE(1)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .sum(sum2),
    .cout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]), .dbg_state(st2));

  seq_addsub #(.WIDTH(64), .SLICE(8)) u_dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]), .sub(sub_v[3]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .sum(sum3),
    .cout(cout_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3]), .dbg_state(st3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum/difference, then reduce to W bits and test range.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] s, output logic co, output logic ov);
    logic signed [66:0] ua, ub, sa, sb, ci, ut, st, lim, modv;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua   = {3'b000, a & mask};
    ub   = {3'b000, b & mask};
    ci   = cin ? 67'sd1 : 67'sd0;
    modv = 67'sd1 <<< w;
    lim  = 67'sd1 <<< (w - 1);
    sa   = a[w-1] ? ua - modv : ua;
    sb   = b[w-1] ? ub - modv : ub;
    if (!sub) begin
      ut = ua + ub + ci;
      st = sa + sb + ci;
      co = (ut >= modv);
    end else begin
      ut = ua - ub - ci;
      st = sa - sb - ci;
      co = (ut >= 67'sd0);
    end
    s  = ut[63:0] & mask;
    ov = (st >= lim) || (st < -lim);
  endfunction

  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input int hold, input bit noisy);
    int lat;
    logic [63:0] es;
    logic ec, eo;
    model(wid[k], a, b, cin, sub, es, ec, eo);
    chk($sformatf("in_ready_pre[%0d]", k), 64'(in_ready_v[k]), 64'd1);
    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub; in_valid_v[k] = 1'b1;
    @(posedge clock); #1;
    in_valid_v[k] = 1'b0;
    a_v[k] = {$urandom, $urandom}; b_v[k] = {$urandom, $urandom};
    cin_v[k] = 1'($urandom_range(0, 1)); sub_v[k] = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid_v[k] && lat < 400) begin
      if (noisy) begin
        in_valid_v[k]  = 1'($urandom_range(0, 1));
        out_ready_v[k] = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
      lat++;
    end
    in_valid_v[k] = 1'b0;
    out_ready_v[k] = 1'b0;
    chk($sformatf("latency[%0d]", k), 64'(lat), 64'(nsl[k]));
    chk($sformatf("sum[%0d]", k), sum_w[k], es);
    chk($sformatf("cout[%0d]", k), 64'(cout_v[k]), 64'(ec));
    chk($sformatf("overflow[%0d]", k), 64'(ovf_v[k]), 64'(eo));
    chk($sformatf("zero[%0d]", k), 64'(zero_v[k]), 64'(es == 64'd0));
    chk($sformatf("in_ready_done[%0d]", k), 64'(in_ready_v[k]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", 64'(out_valid_v[k]), 64'd1);
      chk("hold_sum", sum_w[k], es);
      chk("hold_cout", 64'(cout_v[k]), 64'(ec));
      chk("hold_ovf", 64'(ovf_v[k]), 64'(eo));
      chk("hold_in_ready", 64'(in_ready_v[k]), 64'd0);
    end
    out_ready_v[k] = 1'b1;
    @(posedge clock); #1;
    out_ready_v[k] = 1'b0;
    chk($sformatf("valid_drop[%0d]", k), 64'(out_valid_v[k]), 64'd0);
    chk($sformatf("in_ready_back[%0d]", k), 64'(in_ready_v[k]), 64'd1);
  endtask

  initial begin
    in_valid_v = '0; out_ready_v = '0; cin_v = '0; sub_v = '0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), 64'(in_ready_v[k]), 64'd1);
      chk($sformatf("rst_out_valid[%0d]", k), 64'(out_valid_v[k]), 64'd0);
      chk($sformatf("rst_sum[%0d]", k), sum_w[k], 64'd0);
      chk($sformatf("rst_flags[%0d]", k), 64'({cout_v[k], ovf_v[k], zero_v[k]}), 64'd0);
      chk($sformatf("rst_state[%0d]", k), 64'(st_w[k]), 64'd0);
    end
    reset = 1'b0;

    // Directed cases on the 32/8 instance
    run_op(0, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
    chk("tp1_zero", 64'(zero_v[0]), 64'd0);
    run_op(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 0, 1'b0);
    run_op(0, 64'h8000_0000, 64'd1, 1'b0, 1'b1, 0, 1'b0);
    run_op(0, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b0, 10, 1'b0);
    run_op(0, 64'd0, 64'd0, 1'b1, 1'b1, 0, 1'b0);

    // Reset in the second RUN cycle aborts the operation
    a_v[0] = 64'hDEAD_BEEF; b_v[0] = 64'h0101_0101; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clock); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("abort_sum", sum_w[0], 64'd0);
    chk("abort_flags", 64'({cout_v[0], ovf_v[0], zero_v[0]}), 64'd0);
    chk("abort_state", 64'(st_w[0]), 64'd0);
    run_op(0, 64'd3, 64'd4, 1'b0, 1'b0, 0, 1'b0);

    // Random operations with handshake noise on every configuration
    for (int n = 0; n < 200; n++)
      run_op(0, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1);
    for (int k = 1; k < 4; k++)
      for (int n = 0; n < 1000; n++)
        run_op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
